// File: rtl/jtag_seq_pkg.sv
// ---------------------------------------------------------------------------
// jtag_seq_pkg
// Shared definitions for the JTAG command sequencer:
//   - command opcodes (cmd[2:0])
//   - sequencer state encoding
//   - response flag bit positions
//   - txBit(): picks the transmit bit for a given index and bit order
// ---------------------------------------------------------------------------
package jtag_seq_pkg;

    localparam logic [2:0] OP_SET_CFG = 3'b001;
    localparam logic [2:0] OP_RESET   = 3'b011;
    localparam logic [2:0] OP_SHIFT   = 3'b110;

    localparam int FLAG_LAST_TMS  = 0;
    localparam int FLAG_MSB_FIRST = 1;

    typedef enum logic [2:0] {
        IDLE,
        CFG_STALL,
        GET_DATA,
        BIT_LO,
        BIT_HI,
        RESP
    } seqState_t;

    // Bit idx of the outgoing byte, counted in transmit order.
    function automatic logic txBit(input logic [7:0] data,
                                   input logic [2:0] idx,
                                   input logic       msbFirst);
        return msbFirst ? data[3'd7 - idx] : data[idx];
    endfunction

endpackage

// File: rtl/jtag_cmd_sequencer_if.sv
// ---------------------------------------------------------------------------
// jtag_cmd_sequencer_if
// Host-side FIFO handshake bundle for the JTAG command sequencer.
//   cmd_data/cmd_valid/cmd_ready : input FIFO head and pop strobe
//   rsp_flags/rsp_count/rsp_bits : response pair pushed to output FIFOs
//   rsp_valid/rsp_ready          : response handshake
// Modports: master = FIFO/host side, slave = sequencer side.
// ---------------------------------------------------------------------------
interface jtag_cmd_sequencer_if;
    logic [7:0] cmd_data;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] rsp_flags;
    logic [3:0] rsp_count;
    logic [7:0] rsp_bits;
    logic       rsp_valid;
    logic       rsp_ready;

    modport master (
        output cmd_data, cmd_valid, rsp_ready,
        input  cmd_ready, rsp_flags, rsp_count, rsp_bits, rsp_valid
    );

    modport slave (
        input  cmd_data, cmd_valid, rsp_ready,
        output cmd_ready, rsp_flags, rsp_count, rsp_bits, rsp_valid
    );
endinterface

// File: rtl/jtag_tck_gen.sv
// ---------------------------------------------------------------------------
// jtag_tck_gen
// TCK half-period timer and TCK register.
//   clock, reset_n : UDB clock / async active-low reset
//   div            : half-period length minus one, in clocks
//   reload         : restart the half-period and load tck with level
//   level          : TCK level for the half-period being started
//   halfDone       : current half-period ends on the next rising edge
//   tck            : registered TCK pin
// The counter only restarts on reload; once it reaches zero it parks there
// so a stalled sequencer never sees a spurious second strobe.
// ---------------------------------------------------------------------------
module jtag_tck_gen #(
    parameter int DIV_W = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [DIV_W-1:0] div,
    input  logic             reload,
    input  logic             level,
    output logic             halfDone,
    output logic             tck
);

    logic [DIV_W-1:0] cntReg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cntReg <= '0;
            tck    <= 1'b0;
        end else if (reload) begin
            cntReg <= div;
            tck    <= level;
        end else if (cntReg != '0) begin
            cntReg <= cntReg - 1'b1;
        end
    end

    assign halfDone = (cntReg == '0);

endmodule

// File: rtl/jtag_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// jtag_cmd_sequencer
// Pops command/data bytes from the host FIFO, drives TCK/TMS/TDI, captures
// TDO and presents {flags,count}+bits response pairs.
//   clock, reset_n     : UDB clock / async active-low reset
//   bus (slave)        : command FIFO pop and response push handshakes
//   proceed / stall    : release pulse / held-SET_CFG indicator
//   tck, tms, tdi, tdo : JTAG pins
//   busy               : sequencer not in IDLE
//   err                : sticky illegal-opcode flag
// Commands: SET_CFG (div, bit order), RESET (RST_CLKS TMS-high clocks),
// SHIFT (1..8 bits of the following data byte, optional read-back).
// ---------------------------------------------------------------------------
module jtag_cmd_sequencer
    import jtag_seq_pkg::*;
#(
    parameter int DIV_W    = 4,
    parameter int RST_CLKS = 5
) (
    input  logic                 clock,
    input  logic                 reset_n,
    jtag_cmd_sequencer_if.slave  bus,
    input  logic                 proceed,
    output logic                 stall,
    output logic                 tck,
    output logic                 tms,
    output logic                 tdi,
    input  logic                 tdo,
    output logic                 busy,
    output logic                 err
);

    localparam logic [7:0] RST_LAST = 8'(RST_CLKS - 1);

    seqState_t        state;
    logic [DIV_W-1:0] divReg;
    logic             msbFirst;
    logic             tmsVal;
    logic             rdFlag;
    logic [7:0]       lastIdx;
    logic [7:0]       bitIdx;
    logic [7:0]       dataReg;
    logic [7:0]       rxReg;
    logic [3:0]       rspFlags;
    logic [3:0]       rspCount;
    logic [7:0]       rspBits;
    logic             rspValid;

    logic       pop;
    logic [2:0] opcode;
    logic [7:0] nextIdx;
    logic       tckReload;
    logic       tckLevel;
    logic       halfDone;

    // Pop is combinational on cmd_valid so IDLE can take a new command on
    // its very first clock, keeping back-to-back commands bubble-free.
    assign bus.cmd_ready = bus.cmd_valid && (state == IDLE || state == GET_DATA);
    assign pop           = bus.cmd_valid && bus.cmd_ready;
    assign opcode        = bus.cmd_data[2:0];
    assign nextIdx       = bitIdx + 8'd1;
    assign busy          = (state != IDLE);

    assign bus.rsp_flags = rspFlags;
    assign bus.rsp_count = rspCount;
    assign bus.rsp_bits  = rspBits;
    assign bus.rsp_valid = rspValid;

    // Every half-period starts with a reload; leaving the last BIT_HI also
    // reloads with level 0, which is what returns TCK low.
    assign tckReload = (state == IDLE && pop && opcode == OP_RESET)
                    || (state == GET_DATA && pop)
                    || ((state == BIT_LO || state == BIT_HI) && halfDone);
    assign tckLevel  = (state == BIT_LO);

    jtag_tck_gen #(
        .DIV_W (DIV_W)
    ) u_tckGen (
        .clock    (clock),
        .reset_n  (reset_n),
        .div      (divReg),
        .reload   (tckReload),
        .level    (tckLevel),
        .halfDone (halfDone),
        .tck      (tck)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            divReg   <= '0;
            msbFirst <= 1'b0;
            tmsVal   <= 1'b1;
            rdFlag   <= 1'b0;
            lastIdx  <= '0;
            bitIdx   <= '0;
            dataReg  <= '0;
            rxReg    <= '0;
            stall    <= 1'b0;
            tms      <= 1'b1;
            tdi      <= 1'b0;
            err      <= 1'b0;
            rspFlags <= '0;
            rspCount <= '0;
            rspBits  <= '0;
            rspValid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        case (opcode)
                            OP_SET_CFG: begin
                                divReg   <= DIV_W'(bus.cmd_data[7:4]);
                                msbFirst <= bus.cmd_data[3];
                                stall    <= 1'b1;
                                state    <= CFG_STALL;
                            end
                            OP_RESET: begin
                                // Runs through the shift path with an all-zero
                                // data byte and TMS forced high.
                                tmsVal  <= 1'b1;
                                rdFlag  <= 1'b0;
                                lastIdx <= RST_LAST;
                                bitIdx  <= '0;
                                dataReg <= '0;
                                rxReg   <= '0;
                                tms     <= 1'b1;
                                tdi     <= 1'b0;
                                state   <= BIT_LO;
                            end
                            OP_SHIFT: begin
                                lastIdx <= {5'd0, bus.cmd_data[7:5]};
                                rdFlag  <= bus.cmd_data[4];
                                tmsVal  <= bus.cmd_data[3];
                                state   <= GET_DATA;
                            end
                            default: err <= 1'b1;
                        endcase
                    end
                end
                CFG_STALL: begin
                    if (proceed) begin
                        stall <= 1'b0;
                        state <= IDLE;
                    end
                end
                GET_DATA: begin
                    if (pop) begin
                        dataReg <= bus.cmd_data;
                        bitIdx  <= '0;
                        rxReg   <= '0;
                        tdi     <= txBit(bus.cmd_data, 3'd0, msbFirst);
                        tms     <= tmsVal;
                        state   <= BIT_LO;
                    end
                end
                BIT_LO: begin
                    if (halfDone) begin
                        // TDO captured on the TCK rising edge. MSB-first
                        // shifts in at bit 0 so the result ends up right
                        // aligned; LSB-first places bit i at position i.
                        if (msbFirst) begin
                            rxReg <= {rxReg[6:0], tdo};
                        end else begin
                            rxReg[bitIdx[2:0]] <= tdo;
                        end
                        state <= BIT_HI;
                    end
                end
                BIT_HI: begin
                    if (halfDone) begin
                        if (bitIdx == lastIdx) begin
                            if (rdFlag) begin
                                rspFlags                 <= '0;
                                rspFlags[FLAG_LAST_TMS]  <= tmsVal;
                                rspFlags[FLAG_MSB_FIRST] <= msbFirst;
                                rspCount                 <= lastIdx[3:0] + 4'd1;
                                rspBits                  <= rxReg;
                                rspValid                 <= 1'b1;
                                state                    <= RESP;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            bitIdx <= nextIdx;
                            tdi    <= txBit(dataReg, nextIdx[2:0], msbFirst);
                            state  <= BIT_LO;
                        end
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rspValid <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_jtag_cmd_sequencer
// Directed bench for jtag_cmd_sequencer: reset values, SET_CFG stall,
// TAP reset sequence, LSB/MSB-first shifts, response backpressure with a
// back-to-back command, illegal opcode and reset in the middle of a shift.
// ---------------------------------------------------------------------------
module tb_jtag_cmd_sequencer;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    logic proceed = 1'b0;
    logic tdoTie  = 1'b0;
    wire  stall, tck, tms, tdi, busy, err;
    wire  tdo;

    int vectors     = 0;
    int miscompares = 0;

    logic tdiQ[$];
    logic tmsQ[$];
    time  riseT[$];

    jtag_cmd_sequencer_if bus();

    assign tdo = tdoTie ? 1'b1 : tdi;

    jtag_cmd_sequencer #(
        .DIV_W    (4),
        .RST_CLKS (5)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus),
        .proceed (proceed),
        .stall   (stall),
        .tck     (tck),
        .tms     (tms),
        .tdi     (tdi),
        .tdo     (tdo),
        .busy    (busy),
        .err     (err)
    );

    always #5 clock = ~clock;

    always @(posedge tck) begin
        tdiQ.push_back(tdi);
        tmsQ.push_back(tms);
        riseT.push_back($time);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clearLog();
        tdiQ.delete();
        tmsQ.delete();
        riseT.delete();
    endtask

    task automatic pushByte(input logic [7:0] b, output bit ok);
        ok = 1'b0;
        bus.cmd_data  = b;
        bus.cmd_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clock);
            if (bus.cmd_ready) begin
                @(posedge clock);
                #1;
                ok = 1'b1;
                break;
            end
        end
        bus.cmd_valid = 1'b0;
        $display("cmd byte %02h popped=%0d t=%0t", b, ok, $time);
    endtask

    task automatic waitIdle(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            tick();
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic waitRsp(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            tick();
            if (bus.rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    function automatic logic [3:0] firstFour(input int dummy);
        logic [3:0] s = 4'b0;
        for (int i = 0; i < 4 && i < tdiQ.size() + dummy; i++) s[3-i] = tdiQ[i];
        return s;
    endfunction

    task automatic test_reset();
        logic [7:0] got;
        tick();
        tick();
        got = {tck, tms, tdi, bus.cmd_ready, stall, bus.rsp_valid, busy, err};
        vectors++;
        if (got !== 8'b0100_0000) begin
            miscompares++;
            $display("FAIL reset_in: outputs got %b want 01000000", got);
        end
        reset_n = 1'b1;
        tick();
        tick();
        got = {tck, tms, tdi, bus.cmd_ready, stall, bus.rsp_valid, busy, err};
        vectors++;
        if (got !== 8'b0100_0000) begin
            miscompares++;
            $display("FAIL reset_out: outputs got %b want 01000000", got);
        end
        $display("test_reset done");
    endtask

    task automatic test_set_cfg();
        bit ok;
        clearLog();
        pushByte(8'h11, ok);
        vectors++;
        if (!ok || stall !== 1'b1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL cfg_stall_rise: popped=%0d stall=%b busy=%b want 1/1/1", ok, stall, busy);
        end
        for (int k = 0; k < 6; k++) tick();
        vectors++;
        if (stall !== 1'b1 || tdiQ.size() != 0) begin
            miscompares++;
            $display("FAIL cfg_stall_hold: stall=%b tck_edges=%0d want 1/0", stall, tdiQ.size());
        end
        proceed = 1'b1;
        tick();
        proceed = 1'b0;
        vectors++;
        if (stall !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL cfg_release: stall=%b busy=%b want 0/0", stall, busy);
        end
        proceed = 1'b1;
        tick();
        proceed = 1'b0;
        tick();
        vectors++;
        if (stall !== 1'b0 || busy !== 1'b0 || tdiQ.size() != 0) begin
            miscompares++;
            $display("FAIL cfg_idle_proceed: stall=%b busy=%b edges=%0d want 0/0/0", stall, busy, tdiQ.size());
        end
        $display("test_set_cfg done");
    endtask

    task automatic test_tap_reset();
        bit ok;
        bit popped;
        clearLog();
        pushByte(8'h03, popped);
        waitIdle(ok);
        vectors++;
        if (!popped || !ok || tdiQ.size() != 5) begin
            miscompares++;
            $display("FAIL tap_reset_edges: popped=%0d idle=%0d edges=%0d want 1/1/5", popped, ok, tdiQ.size());
        end
        for (int i = 0; i < tmsQ.size(); i++) begin
            vectors++;
            if (tmsQ[i] !== 1'b1) begin
                miscompares++;
                $display("FAIL tap_reset_tms[%0d]: got %b want 1", i, tmsQ[i]);
            end
        end
        for (int i = 1; i < riseT.size(); i++) begin
            vectors++;
            if (riseT[i] - riseT[i-1] != 40) begin
                miscompares++;
                $display("FAIL tap_reset_period[%0d]: got %0t want 40", i, riseT[i] - riseT[i-1]);
            end
        end
        vectors++;
        if (tms !== 1'b1 || tck !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL tap_reset_end: tms=%b tck=%b busy=%b want 1/0/0", tms, tck, busy);
        end
        $display("test_tap_reset done edges=%0d", tdiQ.size());
    endtask

    task automatic test_shift_lsb();
        bit ok1, ok2, ok3;
        clearLog();
        tdoTie = 1'b0;
        pushByte(8'h76, ok1);
        pushByte(8'hF9, ok2);
        waitRsp(ok3);
        vectors++;
        if (!(ok1 && ok2 && ok3) || tdiQ.size() != 4) begin
            miscompares++;
            $display("FAIL lsb_edges: handshakes=%0d%0d%0d edges=%0d want 111/4", ok1, ok2, ok3, tdiQ.size());
        end
        vectors++;
        if (firstFour(0) !== 4'b1001 || tmsQ.sum() != 0) begin
            miscompares++;
            $display("FAIL lsb_tdi: seq=%b tms_ones=%0d want 1001/0", firstFour(0), tmsQ.sum());
        end
        vectors++;
        if (bus.rsp_count !== 4'd4 || bus.rsp_bits !== 8'h09 || bus.rsp_flags !== 4'b0000) begin
            miscompares++;
            $display("FAIL lsb_rsp: count=%0d bits=%02h flags=%b want 4/09/0000",
                     bus.rsp_count, bus.rsp_bits, bus.rsp_flags);
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        vectors++;
        if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL lsb_xfer: rsp_valid=%b busy=%b want 0/0", bus.rsp_valid, busy);
        end
        $display("test_shift_lsb done bits=%02h", bus.rsp_bits);
    endtask

    task automatic test_shift_msb();
        bit ok0, ok1, ok2, ok3;
        pushByte(8'h09, ok0);
        proceed = 1'b1;
        tick();
        proceed = 1'b0;
        clearLog();
        tdoTie = 1'b1;
        pushByte(8'h76, ok1);
        pushByte(8'hF9, ok2);
        waitRsp(ok3);
        vectors++;
        if (!(ok0 && ok1 && ok2 && ok3) || tdiQ.size() != 4 || firstFour(0) !== 4'b1111) begin
            miscompares++;
            $display("FAIL msb_tdi: handshakes=%0d%0d%0d%0d edges=%0d seq=%b want 1111/4/1111",
                     ok0, ok1, ok2, ok3, tdiQ.size(), firstFour(0));
        end
        vectors++;
        if (riseT.size() < 2 || riseT[1] - riseT[0] != 20) begin
            miscompares++;
            $display("FAIL msb_period: rises=%0d want period 20", riseT.size());
        end
        vectors++;
        if (bus.rsp_count !== 4'd4 || bus.rsp_bits !== 8'h0F || bus.rsp_flags !== 4'b0010) begin
            miscompares++;
            $display("FAIL msb_rsp: count=%0d bits=%02h flags=%b want 4/0f/0010",
                     bus.rsp_count, bus.rsp_bits, bus.rsp_flags);
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        $display("test_shift_msb done bits=%02h", bus.rsp_bits);
    endtask

    task automatic test_back_to_back();
        bit ok1, ok2, ok3;
        logic [17:0] got;
        int bad = 0;
        pushByte(8'h76, ok1);
        pushByte(8'hF9, ok2);
        waitRsp(ok3);
        vectors++;
        if (!(ok1 && ok2 && ok3)) begin
            miscompares++;
            $display("FAIL bp_start: handshakes=%0d%0d%0d want 111", ok1, ok2, ok3);
        end
        bus.cmd_data  = 8'h11;
        bus.cmd_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            tick();
            got = {bus.rsp_valid, bus.rsp_flags, bus.rsp_count, bus.rsp_bits, bus.cmd_ready};
            vectors++;
            if (got !== {1'b1, 4'b0010, 4'd4, 8'h0F, 1'b0}) begin
                miscompares++;
                bad++;
                if (bad < 4) $display("FAIL bp_hold[%0d]: {valid,flags,count,bits,ready}=%h want %h",
                                      k, got, {1'b1, 4'b0010, 4'd4, 8'h0F, 1'b0});
            end
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        vectors++;
        if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_xfer: rsp_valid=%b cmd_ready=%b want 0/1", bus.rsp_valid, bus.cmd_ready);
        end
        tick();
        bus.cmd_valid = 1'b0;
        vectors++;
        if (stall !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_next_cmd: stall=%b want 1", stall);
        end
        proceed = 1'b1;
        tick();
        proceed = 1'b0;
        $display("test_back_to_back done");
    endtask

    task automatic test_illegal_and_reset();
        bit ok, ok1, ok2;
        int edgesAtReset;
        logic [7:0] got;
        pushByte(8'h00, ok);
        vectors++;
        if (!ok || err !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL illegal_op: popped=%0d err=%b busy=%b want 1/1/0", ok, err, busy);
        end
        clearLog();
        tdoTie = 1'b0;
        pushByte(8'h76, ok1);
        pushByte(8'hF9, ok2);
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (tdiQ.size() >= 2) begin
                ok = 1'b1;
                break;
            end
        end
        vectors++;
        if (!(ok && ok1 && ok2)) begin
            miscompares++;
            $display("FAIL midshift_start: handshakes=%0d%0d edges_seen=%0d want 11/1", ok1, ok2, ok);
        end
        reset_n = 1'b0;
        #1;
        got = {tck, tms, tdi, bus.cmd_ready, stall, bus.rsp_valid, busy, err};
        vectors++;
        if (got !== 8'b0100_0000) begin
            miscompares++;
            $display("FAIL midshift_reset: outputs got %b want 01000000", got);
        end
        edgesAtReset = tdiQ.size();
        tick();
        tick();
        reset_n = 1'b1;
        for (int k = 0; k < 20; k++) tick();
        vectors++;
        if (busy !== 1'b0 || bus.rsp_valid !== 1'b0 || err !== 1'b0 || tdiQ.size() != edgesAtReset) begin
            miscompares++;
            $display("FAIL post_reset: busy=%b rsp_valid=%b err=%b new_edges=%0d want 0/0/0/0",
                     busy, bus.rsp_valid, err, tdiQ.size() - edgesAtReset);
        end
        $display("test_illegal_and_reset done");
    endtask

    initial begin
        bus.cmd_data  = 8'h00;
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_set_cfg();
        test_tap_reset();
        test_shift_lsb();
        test_shift_msb();
        test_back_to_back();
        test_illegal_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/jtag_cmd_sequencer.md
Name: jtag_cmd_sequencer

Overview:
- Command sequencer for the UDB JTAG engine: pops command/data bytes from the host input FIFO, drives TCK/TMS/TDI, captures TDO and pushes {flags,count}+data response pairs to the output FIFOs.
- Owns bit ordering, TCK divider, TAP reset sequence and the stall/proceed handshake for configuration commands.
- Sits between the datapath FIFO interfaces and the JTAG pins.

Parameters:
- DIV_W, 4, width of the TCK half-period divider field.
- RST_CLKS, 5, number of TMS-high TCK cycles issued by the RESET command.

Ports:
- clock  in  1  UDB clock; all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- cmd_data  in  8  command or data byte at input FIFO head.
- cmd_valid  in  1  input FIFO not empty.
- cmd_ready  out  1  pop strobe; byte consumed when cmd_valid & cmd_ready.
- proceed  in  1  one-clock pulse from the control register; releases a stall.
- stall  out  1  high while a SET_CFG is held awaiting proceed.
- rsp_flags  out  4  response flags: [0] last TMS, [1] msb_first, [3:2] 0.
- rsp_count  out  4  bits shifted (1..8).
- rsp_bits  out  8  captured TDO, right-aligned.
- rsp_valid  out  1  response pair present.
- rsp_ready  in  1  output FIFOs can accept; transfer when rsp_valid & rsp_ready.
- tck, tms, tdi  out  1 each  JTAG pins.
- tdo  in  1  JTAG TDO.
- busy  out  1  high in any state other than IDLE.
- err  out  1  sticky illegal-opcode flag; cleared only by reset.

Behaviour:
- Reset: tck=0, tms=1, tdi=0, cmd_ready=0, stall=0, rsp_valid=0, busy=0, err=0, divider=0, msb_first=0, state=IDLE.
- Opcode = cmd_data[2:0]:
  - 001 SET_CFG: div=cmd[7:4], msb_first=cmd[3].
  - 011 RESET: RST_CLKS TCK cycles with TMS=1, then tms holds 1.
  - 110 SHIFT: n=cmd[7:5]+1, tms_val=cmd[3], rd=cmd[4]; next byte is data.
  - Others: popped and discarded, err<=1.
- States: IDLE, CFG_STALL, GET_DATA, BIT_LO, BIT_HI, RESP.
- IDLE: cmd_ready=1 for one clock when cmd_valid; decode on the pop edge.
- SET_CFG:
  - Config latched on the pop edge.
  - Enter CFG_STALL; stall=1 from the next clock.
  - proceed -> IDLE; stall drops the clock after proceed.
  - proceed outside CFG_STALL is ignored.
- GET_DATA: wait cmd_valid; pop; load shift reg; bit index=0.
- BIT_LO:
  - tck=0; tdi = msb_first ? data[7-i] : data[i]; tms = tms_val (1 for RESET).
  - Hold div+1 clocks -> BIT_HI.
- BIT_HI:
  - tck=1 for div+1 clocks; tdo sampled on the clock entering BIT_HI.
  - Captured bit shifts in at the same end as transmit order; result right-aligned to n bits.
  - Last bit -> tck=0, then RESP if rd else IDLE; otherwise i+1 -> BIT_LO.
- Minimum TCK period (div=0) = 2 clocks; divider counter wraps only via explicit reload, never free-runs.
- RESP:
  - rsp_valid=1 with stable fields until rsp_ready.
  - Transfer -> IDLE next clock.
  - cmd_ready=0 throughout RESP (backpressure).
- SHIFT with n=8 and rd=0 produces no response.
- Back-to-back: IDLE accepts the next command the clock after RESP/last BIT_HI; no bubble beyond one clock.
- reset_n low mid-shift: immediate return to reset values; partial response discarded; the consumed byte is not re-read.

Decomposition:
- Package jtag_seq_pkg: opcode localparams (OP_SET_CFG, OP_RESET, OP_SHIFT), state encoding, flag bit indices.
- One sub-module: jtag_tck_gen (divider counter, half-period done strobe, tck register).

Test Plan:
- SET_CFG 8'b0001_0001 (div=1, lsb) -> stall=1 one clock after pop, stays until proceed pulse; stall=0 the clock after; no TCK activity.
- RESET 8'b0000_0011 at div=1 -> exactly 5 tck rising edges, tms=1 throughout, each TCK period 4 clocks, busy low afterwards.
- SHIFT 8'b0111_0110 + data 8'hF9, lsb-first, tdo looped to tdi -> 4 edges, tdi 1,0,0,1, tms=0, rsp_count=4, rsp_bits=8'h09, rsp_flags=4'b0000.
- Same shift with msb_first=1 and tdo tied 1 -> tdi sequence 1,1,1,1 from 8'hF9[7:4], rsp_bits=8'h0F, rsp_flags[1]=1.
- SHIFT read with rsp_ready held low 50 clocks -> rsp_valid stays 1 with stable fields, cmd_ready=0, next command is not popped until transfer.
- Opcode 3'b000, then reset_n pulse mid-SHIFT -> err=1 after the illegal opcode; on reset all outputs return to reset values, err=0.
